// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin arbiter that lets two requesters share one
// external ALU. One operation is in flight at a time: IDLE -> EXEC -> RESP.
// Optional build macro ALU_ARB_PERF_EN adds saturating grant/stall counters.
module alu_share_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  // requester 0
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [4:0]  req0_shamt,
  input  logic        req0_instr5,
  input  logic [3:0]  req0_alufn,
  output logic        req0_ready,
  // requester 1
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [4:0]  req1_shamt,
  input  logic        req1_instr5,
  input  logic [3:0]  req1_alufn,
  output logic        req1_ready,
  // shared ALU
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_shamt,
  output logic        alu_instr5,
  output logic [3:0]  alu_alufn,
  input  logic [31:0] alu_r,
  input  logic        alu_cf,
  input  logic        alu_zf,
  input  logic        alu_vf,
  input  logic        alu_sf,
  // response
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_r,
  output logic [3:0]  rsp_flags,
  input  logic        rsp_ready
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [15:0] perf_grant0,
  output logic [15:0] perf_grant1,
  output logic [15:0] perf_stall
`endif
);

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 5;
  localparam int unsigned FW = 4;
  localparam int unsigned NW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           w_grant0;
  logic           w_grant1;
  logic           r_last_grant;   // id of the most recent grant

  logic [DW-1:0]  r_a;
  logic [DW-1:0]  r_b;
  logic [SW-1:0]  r_shamt;
  logic           r_instr5;
  logic [FW-1:0]  r_alufn;
  logic           r_id;

  logic           r_rsp_valid;
  logic           r_rsp_id;
  logic [DW-1:0]  r_rsp_r;
  logic [NW-1:0]  r_rsp_flags;

  logic [DW-1:0]  w_sel_a;
  logic [DW-1:0]  w_sel_b;
  logic [SW-1:0]  w_sel_shamt;
  logic           w_sel_instr5;
  logic [FW-1:0]  w_sel_alufn;

  // Next-state and round-robin grant; grants only happen in IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_grant0    = 1'b0;
    w_grant1    = 1'b0;
    case (r_state)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          w_grant0 = r_last_grant;
          w_grant1 = ~r_last_grant;
        end else begin
          w_grant0 = req0_valid;
          w_grant1 = req1_valid;
        end
        if (req0_valid || req1_valid) begin
          w_state_nxt = EXEC;
        end
      end
      EXEC: w_state_nxt = RESP;
      RESP: begin
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand select for the winning requester
  assign w_sel_a      = w_grant1 ? req1_a      : req0_a;
  assign w_sel_b      = w_grant1 ? req1_b      : req0_b;
  assign w_sel_shamt  = w_grant1 ? req1_shamt  : req0_shamt;
  assign w_sel_instr5 = w_grant1 ? req1_instr5 : req0_instr5;
  assign w_sel_alufn  = w_grant1 ? req1_alufn  : req0_alufn;

  // Ready is combinational in the grant cycle, forced low while in reset
  assign req0_ready = w_grant0 & rst_n;
  assign req1_ready = w_grant1 & rst_n;

  // ALU is always fed from latched operands, never directly from requesters
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_shamt  = r_shamt;
  assign alu_instr5 = r_instr5;
  assign alu_alufn  = r_alufn;

  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_r      = r_rsp_r;
  assign rsp_flags  = r_rsp_flags;

  // State, operand latch and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_a          <= '0;
      r_b          <= '0;
      r_shamt      <= '0;
      r_instr5     <= 1'b0;
      r_alufn      <= '0;
      r_id         <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_r      <= '0;
      r_rsp_flags  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant0 || w_grant1) begin
        r_a          <= w_sel_a;
        r_b          <= w_sel_b;
        r_shamt      <= w_sel_shamt;
        r_instr5     <= w_sel_instr5;
        r_alufn      <= w_sel_alufn;
        r_id         <= w_grant1;
        r_last_grant <= w_grant1;
      end
      if (r_state == EXEC) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= r_id;
        r_rsp_r     <= alu_r;
        r_rsp_flags <= {alu_cf, alu_zf, alu_vf, alu_sf};
      end else if ((r_state == RESP) && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_ARB_PERF_EN
  localparam int unsigned PW = 16;

  logic [PW-1:0] r_perf_grant0;
  logic [PW-1:0] r_perf_grant1;
  logic [PW-1:0] r_perf_stall;
  logic          w_stall;

  assign w_stall     = (req0_valid & ~w_grant0) | (req1_valid & ~w_grant1);
  assign perf_grant0 = r_perf_grant0;
  assign perf_grant1 = r_perf_grant1;
  assign perf_stall  = r_perf_stall;

  // Saturating grant and stall counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_grant0 <= '0;
      r_perf_grant1 <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (w_grant0 && (r_perf_grant0 != '1)) begin
        r_perf_grant0 <= r_perf_grant0 + PW'(1);
      end
      if (w_grant1 && (r_perf_grant1 != '1)) begin
        r_perf_grant1 <= r_perf_grant1 + PW'(1);
      end
      if (w_stall && (r_perf_stall != '1)) begin
        r_perf_stall <= r_perf_stall + PW'(1);
      end
    end
  end
`endif

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset; synchronous and active-low.
REQ-003 SHALL have ports, per requester k in {0,1}: reqk_valid  input  1  request pending.
REQ-004 SHALL have ports: reqk_a, reqk_b  input  32 each  operands.
REQ-005 SHALL have ports: reqk_shamt  input  5  immediate shift amount.
REQ-006 SHALL have ports: reqk_instr5  input  1  selects register (1) or immediate (0) shift.
REQ-007 SHALL have ports: reqk_alufn  input  4  ALU function code.
REQ-008 SHALL have ports: reqk_ready  output  1  request accepted this cycle.
REQ-009 SHALL have ports: alu_a, alu_b  output  32  to shared ALU; alu_shamt  output  5; alu_instr5  output  1; alu_alufn  output  4.
REQ-010 SHALL have ports: alu_r  input  32  ALU result; alu_cf, alu_zf, alu_vf, alu_sf  input  1 each  ALU flags.
REQ-011 SHALL have ports: rsp_valid  output  1; rsp_id  output  1  owning requester; rsp_r  output  32; rsp_flags  output  4  {cf,zf,vf,sf}; rsp_ready  input  1.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, RESP; one operation in flight at a time.
REQ-013 In IDLE with any reqk_valid, SHALL grant one requester, assert its reqk_ready combinationally in that cycle only, latch its operands/alufn/shamt/instr5 and id, and go to EXEC.
REQ-014 Arbitration SHALL be round-robin: on simultaneous valid, grant the requester not granted last; after reset requester 0 has priority.
REQ-015 reqk_ready SHALL be 0 in EXEC and RESP and for the non-granted requester.
REQ-016 In EXEC, alu_* SHALL be driven from latched registers; result and flags SHALL be registered at end of EXEC; next state RESP.
REQ-017 Outside EXEC, alu_* SHALL still reflect latched registers (stable, no glitching from requester inputs).
REQ-018 In RESP, rsp_valid SHALL be 1 with rsp_r/rsp_flags/rsp_id stable until rsp_ready=1; on that handshake go to IDLE.
REQ-019 Latency SHALL be: accept in cycle N, rsp_valid in cycle N+2; throughput one op per 3 cycles minimum.
REQ-020 rsp_ready high outside RESP SHALL be ignored; a request dropped by its requester before ready SHALL not be granted.
REQ-021 alufn values SHALL be passed through unchecked; rsp_r returns whatever the ALU produces (e.g. 99 for undefined codes).

Reset
REQ-022 With rst_n=0 at a rising edge: state IDLE, last-grant pointer selects requester 0 next, all latched registers 0, rsp_valid=0, rsp_id=0, rsp_r=0, rsp_flags=0, reqk_ready=0 during reset.
REQ-023 Reset in EXEC or RESP SHALL abandon the in-flight operation with no response issued.

Configuration
REQ-024 Macro ALU_ARB_PERF_EN SHALL, when defined, add outputs perf_grant0, perf_grant1 (16 bits each) counting grants per requester, and perf_stall (16 bits) counting cycles with a valid request not granted; all saturate at 0xFFFF and reset to 0.
REQ-025 Without ALU_ARB_PERF_EN, those ports and counters SHALL not exist; all other behaviour is identical.

Verification
REQ-026 Single req0: a=5, b=3, alufn=ALU_ADD -> req0_ready in cycle N, rsp_valid cycle N+2, rsp_id=0, rsp_r=8, zf=0.
REQ-027 Both valid every cycle from reset, rsp_ready=1 -> grants alternate 0,1,0,1; each rsp_id matches the grant order.
REQ-028 req1 SUB a=7, b=7, rsp_ready held 0 for 5 cycles -> rsp_valid held, rsp_r=0, zf=1 stable; req0_ready=0 throughout; IDLE reached after rsp_ready=1.
REQ-029 rst_n=0 asserted during EXEC -> next cycle rsp_valid=0, state IDLE, following simultaneous request granted to requester 0.
REQ-030 ALU_ARB_PERF_EN defined, both requesters valid for 30 cycles -> perf_grant0=5, perf_grant1=5, perf_stall counts every cycle with an ungranted valid; with the counter preloaded at 0xFFFF and incremented, it stays at 0xFFFF.
